pipe_stage_buf: RTL and testbench
=================================

# pipe_stage_buf

Parametrised elastic pipeline-stage register carrying an instruction word and its PC between two adjacent CPU stages, e.g. F→D or D→E. It replaces the plain enable/reset stage register. It adds:
- a valid/ready handshake;
- a 2-entry skid buffer, so upstream ready is driven from a flop;
- a flush that inserts a bubble;
- a saturating stall-cycle counter for performance debug.

Throughput is one instruction per cycle. Latency is one cycle.

## Interface
Parameters:
- INSTR_W, 32, instruction payload width
- PC_W, 32, PC payload width
- NOP_INSTR, {INSTR_W{1'b0}}, instruction value driven while out_valid=0
- PC_RST, 32'h0000_3000, PC value driven while out_valid=0
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  single clock; all state updates on its rising edge
- reset_n  in  1  synchronous, active-low reset
- in_valid  in  1  upstream beat present
- in_ready  out  1  buffer can accept a beat; driven directly from registers
- in_instr  in  INSTR_W  upstream instruction
- in_pc  in  PC_W  upstream PC
- out_valid  out  1  downstream beat present
- out_ready  in  1  downstream accepts the beat
- out_instr  out  INSTR_W  registered instruction
- out_pc  out  PC_W  registered PC
- flush  in  1  discard all buffered and incoming beats
- stall_cnt  out  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0

## Operation
- Handshake events:
  - in_fire = in_valid & in_ready
  - out_fire = out_valid & out_ready
- Storage:
  - main register (M) drives the out_* ports;
  - skid register (S) is hidden.
- in_ready = !S.valid.
- States:
  - EMPTY: M and S both invalid.
  - ONE: M valid, S invalid.
  - TWO: M and S both valid.
- EMPTY transitions:
  - in_fire → ONE; M loads the incoming beat.
- ONE transitions:
  - in_fire & out_fire → ONE; M loads the new beat.
  - in_fire & !out_fire → TWO; S loads the beat and M holds.
  - !in_fire & out_fire → EMPTY.
  - neither → hold.
- TWO transitions (in_ready=0):
  - out_fire → ONE; M loads S, and S is invalidated.
  - otherwise → hold.
- Payload while M is invalid:
  - out_instr = NOP_INSTR and out_pc = PC_RST.
  - The payload flops are loaded with these values on every transition into EMPTY.
  - The outputs never show stale data.
- Ordering: beats leave in acceptance order. No beat is lost or duplicated.
- Flush:
  - Next state is EMPTY, and S.valid=0.
  - A beat offered on the flush cycle is dropped, even if in_ready=1.
  - An out_fire on the flush cycle is still a legal downstream transfer.
  - stall_cnt is unaffected.
- stall_cnt:
  - Increments by 1 on each cycle with out_valid & !out_ready.
  - Saturates at all-ones and never wraps.
  - Cleared only by reset.

## Timing
- Reset (reset_n=0 at a clock edge), on the next cycle:
  - out_valid=0, in_ready=1
  - out_instr=NOP_INSTR, out_pc=PC_RST
  - stall_cnt=0
- Event priority: reset_n=0 > flush > normal handshake.
- Reset mid-operation discards both entries, even with flush or in_valid asserted.
- Latency: a beat accepted at edge N is on out_* after edge N, i.e. visible during cycle N+1.
- Back-pressure: in_ready falls one cycle after the first beat is captured into S. It rises in the cycle after the out_fire that drains S.
- in_ready and out_valid have no combinational path from any input.
- With out_ready held at 1, sustained throughput is 1 beat/cycle and S is never used.

## Test plan
- Reset: hold reset_n=0 for 2 cycles with in_valid=1, in_pc=0x3004 → out_valid=0, out_pc=0x3000, out_instr=0, in_ready=1, stall_cnt=0.
- Streaming: out_ready=1, send PCs 0x3000/0x3004/0x3008 on consecutive cycles → they appear on out_pc on the following 3 cycles; in_ready stays 1 throughout.
- Back-pressure:
  - Stimulus: out_ready=0 for 3 cycles while offering A(0x3000), B(0x3004), C(0x3008).
  - During the stall: A is held on the output, B is captured into S, and in_ready=0 from the cycle after B, so C waits upstream.
  - After out_ready=1: the output sequence is exactly A, B, C, and stall_cnt=3.
- Flush in TWO with in_valid=1 → next cycle out_valid=0, out_instr=NOP_INSTR, in_ready=1; the concurrently offered beat never appears on the output.
- Saturation: CNT_W=4, out_valid=1, out_ready=0 for 20 cycles → stall_cnt=15 and stays at 15.
- Reset with flush=1 and in_valid=1 asserted together in state TWO → next cycle reaches the reset state with stall_cnt=0; no beat is emitted afterwards.

Source files
------------

// File: rtl/pipe_stage_buf.sv
// Elastic pipeline-stage register for an instruction word and its PC.
// A main register (M) drives the outputs and a hidden skid register (S) catches
// the one beat that may arrive while downstream stalls, so in_ready comes from a flop.
// Also provides a bubble-inserting flush and a saturating stall-cycle counter.
module pipe_stage_buf #(
  parameter int unsigned          INSTR_W   = 32,
  parameter int unsigned          PC_W      = 32,
  parameter logic [INSTR_W-1:0]   NOP_INSTR = {INSTR_W{1'b0}},
  parameter logic [PC_W-1:0]      PC_RST    = PC_W'(32'h0000_3000),
  parameter int unsigned          CNT_W     = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  input  logic               flush,
  output logic [CNT_W-1:0]   stall_cnt
);

  logic               m_valid_q, m_valid_d;
  logic [INSTR_W-1:0] m_instr_q, m_instr_d;
  logic [PC_W-1:0]    m_pc_q,    m_pc_d;
  logic               s_valid_q, s_valid_d;
  logic [INSTR_W-1:0] s_instr_q, s_instr_d;
  logic [PC_W-1:0]    s_pc_q,    s_pc_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

  logic in_fire;
  logic out_fire;

  // Handshake outputs come straight from flops; no input-to-ready/valid path.
  assign in_ready  = ~s_valid_q;
  assign out_valid = m_valid_q;
  assign out_instr = m_instr_q;
  assign out_pc    = m_pc_q;
  assign stall_cnt = stall_cnt_q;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = m_valid_q & out_ready;

  // Next-state for M and S: EMPTY / ONE / TWO encoded by the two valid bits.
  always_comb begin
    m_valid_d = m_valid_q;
    m_instr_d = m_instr_q;
    m_pc_d    = m_pc_q;
    s_valid_d = s_valid_q;
    s_instr_d = s_instr_q;
    s_pc_d    = s_pc_q;

    if (flush) begin
      // Bubble: drop everything held and anything offered this cycle.
      m_valid_d = 1'b0;
      m_instr_d = NOP_INSTR;
      m_pc_d    = PC_RST;
      s_valid_d = 1'b0;
      s_instr_d = NOP_INSTR;
      s_pc_d    = PC_RST;
    end else if (!m_valid_q) begin
      if (in_fire) begin
        m_valid_d = 1'b1;
        m_instr_d = in_instr;
        m_pc_d    = in_pc;
      end
    end else if (!s_valid_q) begin
      if (in_fire && out_fire) begin
        m_instr_d = in_instr;
        m_pc_d    = in_pc;
      end else if (in_fire) begin
        s_valid_d = 1'b1;
        s_instr_d = in_instr;
        s_pc_d    = in_pc;
      end else if (out_fire) begin
        m_valid_d = 1'b0;
        m_instr_d = NOP_INSTR;
        m_pc_d    = PC_RST;
      end
    end else begin
      if (out_fire) begin
        m_instr_d = s_instr_q;
        m_pc_d    = s_pc_q;
        s_valid_d = 1'b0;
      end
    end
  end

  // Stall counter: counts stalled output cycles and sticks at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (m_valid_q && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      m_valid_q   <= 1'b0;
      m_instr_q   <= NOP_INSTR;
      m_pc_q      <= PC_RST;
      s_valid_q   <= 1'b0;
      s_instr_q   <= NOP_INSTR;
      s_pc_q      <= PC_RST;
      stall_cnt_q <= '0;
    end else begin
      m_valid_q   <= m_valid_d;
      m_instr_q   <= m_instr_d;
      m_pc_q      <= m_pc_d;
      s_valid_q   <= s_valid_d;
      s_instr_q   <= s_instr_d;
      s_pc_q      <= s_pc_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: reset, streaming, back-pressure, flush,
// reset-over-flush, and counter saturation on a narrow-counter instance.
module tb_pipe_stage_buf;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        flush;
  logic [15:0] stall_cnt;

  // Second instance with a 4-bit counter for saturation.
  logic        s_in_valid;
  logic        s_in_ready;
  logic        s_out_valid;
  logic        s_out_ready;
  logic [31:0] s_out_instr;
  logic [31:0] s_out_pc;
  logic [3:0]  s_stall_cnt;

  int total;
  int bad;

  pipe_stage_buf u_dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_pc    (out_pc),
    .flush     (flush),
    .stall_cnt (stall_cnt)
  );

  pipe_stage_buf #(
    .CNT_W (4)
  ) u_dut_sat (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (s_in_valid),
    .in_ready  (s_in_ready),
    .in_instr  (32'h1234_5678),
    .in_pc     (32'h0000_3100),
    .out_valid (s_out_valid),
    .out_ready (s_out_ready),
    .out_instr (s_out_instr),
    .out_pc    (s_out_pc),
    .flush     (1'b0),
    .stall_cnt (s_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic v, input logic [31:0] instr,
                           input logic [31:0] pc);
    check({tag, ".out_valid"}, 64'(out_valid), 64'(v));
    check({tag, ".out_instr"}, 64'(out_instr), 64'(instr));
    check({tag, ".out_pc"},    64'(out_pc),    64'(pc));
  endtask

  task automatic offer(input logic v, input logic [31:0] instr, input logic [31:0] pc);
    in_valid = v;
    in_instr = instr;
    in_pc    = pc;
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    reset_n     = 1'b0;
    flush       = 1'b0;
    out_ready   = 1'b0;
    s_in_valid  = 1'b0;
    s_out_ready = 1'b0;
    offer(1'b1, 32'hAAAA_0001, 32'h0000_3004);

    // Reset held 2 cycles with a beat offered.
    tick();
    tick();
    check_out("reset", 1'b0, 32'h0, 32'h3000);
    check("reset.in_ready", 64'(in_ready), 64'd1);
    check("reset.stall_cnt", 64'(stall_cnt), 64'd0);

    reset_n = 1'b1;
    offer(1'b0, 32'h0, 32'h0);
    tick();
    check("idle.out_valid", 64'(out_valid), 64'd0);

    // Streaming with out_ready=1: one beat per cycle, one-cycle latency.
    out_ready = 1'b1;
    offer(1'b1, 32'h1000_0000, 32'h3000);
    tick();
    check_out("stream0", 1'b1, 32'h1000_0000, 32'h3000);
    check("stream0.in_ready", 64'(in_ready), 64'd1);
    offer(1'b1, 32'h1000_0001, 32'h3004);
    tick();
    check_out("stream1", 1'b1, 32'h1000_0001, 32'h3004);
    check("stream1.in_ready", 64'(in_ready), 64'd1);
    offer(1'b1, 32'h1000_0002, 32'h3008);
    tick();
    check_out("stream2", 1'b1, 32'h1000_0002, 32'h3008);
    check("stream2.in_ready", 64'(in_ready), 64'd1);
    offer(1'b0, 32'h0, 32'h0);
    tick();
    check_out("stream_drain", 1'b0, 32'h0, 32'h3000);
    check("stream.stall_cnt", 64'(stall_cnt), 64'd0);

    // Back-pressure: A held, B into skid, C waits upstream.
    out_ready = 1'b0;
    offer(1'b1, 32'hA000_000A, 32'h3000);
    tick();
    check_out("bp.A_loaded", 1'b1, 32'hA000_000A, 32'h3000);
    check("bp.A_loaded.in_ready", 64'(in_ready), 64'd1);
    check("bp.A_loaded.stall_cnt", 64'(stall_cnt), 64'd0);
    offer(1'b1, 32'hB000_000B, 32'h3004);
    tick();
    check_out("bp.B_skid", 1'b1, 32'hA000_000A, 32'h3000);
    check("bp.B_skid.in_ready", 64'(in_ready), 64'd0);
    check("bp.B_skid.stall_cnt", 64'(stall_cnt), 64'd1);
    offer(1'b1, 32'hC000_000C, 32'h3008);
    tick();
    check_out("bp.C_wait1", 1'b1, 32'hA000_000A, 32'h3000);
    check("bp.C_wait1.in_ready", 64'(in_ready), 64'd0);
    tick();
    check_out("bp.C_wait2", 1'b1, 32'hA000_000A, 32'h3000);
    check("bp.C_wait2.stall_cnt", 64'(stall_cnt), 64'd3);
    out_ready = 1'b1;
    tick();
    check_out("bp.out_B", 1'b1, 32'hB000_000B, 32'h3004);
    check("bp.out_B.in_ready", 64'(in_ready), 64'd1);
    tick();
    check_out("bp.out_C", 1'b1, 32'hC000_000C, 32'h3008);
    offer(1'b0, 32'h0, 32'h0);
    tick();
    check_out("bp.empty", 1'b0, 32'h0, 32'h3000);
    check("bp.stall_cnt", 64'(stall_cnt), 64'd3);

    // Flush in TWO with a beat offered.
    out_ready = 1'b0;
    offer(1'b1, 32'hD000_000D, 32'h300C);
    tick();
    offer(1'b1, 32'hE000_000E, 32'h3010);
    tick();
    check("fl.two.in_ready", 64'(in_ready), 64'd0);
    check("fl.two.stall_cnt", 64'(stall_cnt), 64'd4);
    flush = 1'b1;
    offer(1'b1, 32'hF000_000F, 32'h3014);
    tick();
    check_out("fl.after", 1'b0, 32'h0, 32'h3000);
    check("fl.after.in_ready", 64'(in_ready), 64'd1);
    check("fl.after.stall_cnt", 64'(stall_cnt), 64'd5);
    flush = 1'b0;
    offer(1'b0, 32'h0, 32'h0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("fl.no_emit", 64'(out_valid), 64'd0);
    end

    // Reset with flush and in_valid in TWO.
    out_ready = 1'b0;
    offer(1'b1, 32'h6000_0006, 32'h3018);
    tick();
    offer(1'b1, 32'h7000_0007, 32'h301C);
    tick();
    check("rst2.two.in_ready", 64'(in_ready), 64'd0);
    check("rst2.two.stall_cnt", 64'(stall_cnt), 64'd6);
    reset_n = 1'b0;
    flush   = 1'b1;
    offer(1'b1, 32'h9000_0009, 32'h3020);
    tick();
    check_out("rst2.after", 1'b0, 32'h0, 32'h3000);
    check("rst2.after.in_ready", 64'(in_ready), 64'd1);
    check("rst2.after.stall_cnt", 64'(stall_cnt), 64'd0);
    reset_n   = 1'b1;
    flush     = 1'b0;
    offer(1'b0, 32'h0, 32'h0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst2.no_emit", 64'(out_valid), 64'd0);
    end

    // Saturation on the 4-bit counter instance.
    check("sat.reset_cnt", 64'(s_stall_cnt), 64'd0);
    s_in_valid = 1'b1;
    tick();
    s_in_valid = 1'b0;
    check("sat.loaded", 64'(s_out_valid), 64'd1);
    check("sat.start_cnt", 64'(s_stall_cnt), 64'd0);
    for (int i = 1; i <= 20; i++) begin
      tick();
      check($sformatf("sat.cnt%0d", i), 64'(s_stall_cnt), (i < 15) ? 64'(i) : 64'd15);
    end
    check("sat.held_out", 64'(s_out_pc), 64'h3100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
